axi_rd_mst: RTL and testbench
=============================

# axi_rd_mst

AXI4 read-only master that issues a programmed sequence of INCR read bursts on the AR channel and consumes the R channel beats. It sits directly upstream of the team's AXI read slave, driving its AR inputs and sinking its R outputs. It keeps one transaction outstanding, matching the slave's single-entry request buffer, and reports completion, beat count, last data and sticky protocol/response errors.

## Interface
- ID_W, 4, arid width
- ADDR_W, 32, address width
- LEN_W, 8, arlen width
- SIZE_W, 3, arsize width
- BURST_W, 2, arburst width
- DATA_W, 32, rdata width (power of 2, ≥8)
- RESP_W, 2, rresp width
- NUM_W, 8, burst-count width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  permits issuing new AR requests
- start  in  1  single-cycle pulse; loads cfg_* and begins a sequence
- cfg_addr  in  ADDR_W  first burst start address
- cfg_len  in  LEN_W  arlen for every burst (beats-1)
- cfg_num  in  NUM_W  number of bursts
- axi_mst_arvalid / arready  out / in  1  AR handshake
- axi_mst_arid  out  ID_W  burst index, low bits, starts at 0
- axi_mst_araddr  out  ADDR_W  burst address
- axi_mst_arlen  out  LEN_W  latched cfg_len
- axi_mst_arsize  out  SIZE_W  constant log2(DATA_W/8)
- axi_mst_arburst  out  BURST_W  constant 2'b01 (INCR)
- axi_mst_rvalid / rready  in / out  1  R handshake
- axi_mst_rdata  in  DATA_W;  axi_mst_rresp  in  RESP_W;  axi_mst_rlast  in  1
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at sequence end
- resp_err  out  1  sticky: any beat with rresp != 0
- last_err  out  1  sticky: rlast mismatched to beat position
- beat_total  out  16  beats accepted in current sequence (saturates at 16'hFFFF)
- last_rdata  out  DATA_W  data of most recent accepted beat

## Operation
- FSM states: IDLE, ADDR, DATA, FIN.
- IDLE: start=1 latches cfg_*, clears resp_err, last_err, beat_total, burst index, id → ADDR if cfg_num!=0, else FIN. start ignored outside IDLE.
- ADDR: arvalid = enable. Once arvalid is high it stays high, fields stable, until arready (enable dropping does not retract it). On handshake → DATA.
- DATA: rready=1. Each rvalid&rready: beat_cnt+1, beat_total+1, last_rdata<=rdata; resp_err|=(rresp!=0); last_err|=(rlast != (beat_cnt==len)).
- Burst ends on the beat with beat_cnt==len regardless of rlast. beat_cnt clears. Burst index +1, araddr += (len+1)<<arsize (wraps mod 2^ADDR_W), arid = index[ID_W-1:0] (wraps). → ADDR if index < num, else FIN.
- FIN: done=1 for one cycle → IDLE.
- busy = (state != IDLE).
- Error flags and beat_total hold after done until next accepted start.

## Timing
- Reset values: arvalid=0, rready=0, araddr=0, arid=0, arlen=0, busy=0, done=0, resp_err=0, last_err=0, beat_total=0, last_rdata=0. arsize and arburst are constants.
- start at cycle T → arvalid high at T+1 (if enable).
- AR handshake at T → rready high from T+1.
- Final beat of a non-last burst at T → next arvalid at T+1.
- Final beat of the last burst at T → done at T+1, busy low at T+2.
- cfg_num=0: start at T → done at T+1, no AR issued.
- Reset asserted mid-sequence: all state and outputs return to reset values immediately; no done pulse.
- rvalid while not in DATA: ignored, not counted.

## Test plan
- Against the read slave: start, addr=0, len=3, num=1 → one AR (id 0, arsize=2, arburst=1), 4 beats accepted, rlast on 4th, resp_err=0, last_err=0, beat_total=4, done pulse.
- num=3, addr=0x100, len=1, DATA_W=32 → araddr 0x100, 0x108, 0x110; arid 0, 1, 2; beat_total=6; one done pulse.
- Slave answers addr 0x40 with DECERR, len=0 → resp_err=1 after the beat, done pulse. resp_err holds until next start.
- Model drives rlast on beat 2 of len=3 → last_err=1. Burst still consumes 4 beats. beat_total=4.
- enable=0 at start → arvalid stays 0. Raise enable → arvalid next cycle. Drop enable while arvalid=1 with arready=0 → arvalid held until handshake.
- rst_n low during DATA beat 2 of 4 → all outputs reset, no done. New start afterwards runs cleanly. start pulsed while busy → ignored; cfg unchanged.

Source files
------------

// File: rtl/axi_rd_mst.sv
// AXI4 read-only master: issues a programmed run of INCR read bursts, one
// outstanding at a time, and reports beat count, last data and sticky errors.
module axi_rd_mst #(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned SIZE_W  = 3,
  parameter int unsigned BURST_W = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RESP_W  = 2,
  parameter int unsigned NUM_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [NUM_W-1:0]   cfg_num,
  output logic               axi_mst_arvalid,
  input  logic               axi_mst_arready,
  output logic [ID_W-1:0]    axi_mst_arid,
  output logic [ADDR_W-1:0]  axi_mst_araddr,
  output logic [LEN_W-1:0]   axi_mst_arlen,
  output logic [SIZE_W-1:0]  axi_mst_arsize,
  output logic [BURST_W-1:0] axi_mst_arburst,
  input  logic               axi_mst_rvalid,
  output logic               axi_mst_rready,
  input  logic [DATA_W-1:0]  axi_mst_rdata,
  input  logic [RESP_W-1:0]  axi_mst_rresp,
  input  logic               axi_mst_rlast,
  output logic               busy,
  output logic               done,
  output logic               resp_err,
  output logic               last_err,
  output logic [15:0]        beat_total,
  output logic [DATA_W-1:0]  last_rdata
);

  localparam int unsigned SZ = $clog2(DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, FIN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_arvalid;
  logic               w_rready;
  logic               w_done;
  logic               r_ar_held;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [NUM_W-1:0]   r_num;
  logic [NUM_W-1:0]   r_idx;
  logic [ID_W-1:0]    r_arid;
  logic [LEN_W-1:0]   r_beat_cnt;
  logic               r_resp_err;
  logic               r_last_err;
  logic [15:0]        r_beat_total;
  logic [DATA_W-1:0]  r_last_rdata;
  logic               w_r_hs;
  logic               w_burst_end;
  logic [NUM_W-1:0]   w_idx_inc;
  logic               w_more;
  logic [ADDR_W-1:0]  w_step;

  assign w_r_hs      = (r_state == DATA) && axi_mst_rvalid;
  assign w_burst_end = (r_beat_cnt == r_len);
  assign w_idx_inc   = r_idx + NUM_W'(1);
  assign w_more      = (w_idx_inc < r_num);
  assign w_step      = (ADDR_W'(r_len) + ADDR_W'(1)) << SZ;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs; arvalid stays up once raised even if enable drops
  always_comb begin
    w_next    = r_state;
    w_arvalid = 1'b0;
    w_rready  = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = (cfg_num != '0) ? ADDR : FIN;
      ADDR: begin
        w_arvalid = enable || r_ar_held;
        if (w_arvalid && axi_mst_arready) w_next = DATA;
      end
      DATA: begin
        w_rready = 1'b1;
        if (axi_mst_rvalid && w_burst_end) w_next = w_more ? ADDR : FIN;
      end
      FIN: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Sequence datapath: config latch, burst address/id stepping, beat accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar_held    <= 1'b0;
      r_addr       <= '0;
      r_len        <= '0;
      r_num        <= '0;
      r_idx        <= '0;
      r_arid       <= '0;
      r_beat_cnt   <= '0;
      r_resp_err   <= 1'b0;
      r_last_err   <= 1'b0;
      r_beat_total <= '0;
      r_last_rdata <= '0;
    end else begin
      r_ar_held <= (r_state == ADDR) && w_arvalid && !axi_mst_arready;
      if (r_state == IDLE && start) begin
        r_addr       <= cfg_addr;
        r_len        <= cfg_len;
        r_num        <= cfg_num;
        r_idx        <= '0;
        r_arid       <= '0;
        r_beat_cnt   <= '0;
        r_resp_err   <= 1'b0;
        r_last_err   <= 1'b0;
        r_beat_total <= '0;
      end
      if (w_r_hs) begin
        r_last_rdata <= axi_mst_rdata;
        if (r_beat_total != '1) r_beat_total <= r_beat_total + 16'd1;
        if (axi_mst_rresp != '0) r_resp_err <= 1'b1;
        if (axi_mst_rlast != w_burst_end) r_last_err <= 1'b1;
        if (w_burst_end) begin
          r_beat_cnt <= '0;
          r_idx      <= w_idx_inc;
          r_addr     <= r_addr + w_step;
          r_arid     <= r_arid + ID_W'(1);
        end else begin
          r_beat_cnt <= r_beat_cnt + LEN_W'(1);
        end
      end
    end
  end

  assign axi_mst_arvalid = w_arvalid;
  assign axi_mst_rready  = w_rready;
  assign axi_mst_arid    = r_arid;
  assign axi_mst_araddr  = r_addr;
  assign axi_mst_arlen   = r_len;
  assign axi_mst_arsize  = SIZE_W'(SZ);
  assign axi_mst_arburst = BURST_W'(1);
  assign busy            = (r_state != IDLE);
  assign done            = w_done;
  assign resp_err        = r_resp_err;
  assign last_err        = r_last_err;
  assign beat_total      = r_beat_total;
  assign last_rdata      = r_last_rdata;

endmodule

// File: tb/tb_axi_rd_mst.sv
// Directed testbench for axi_rd_mst; the bench plays the read slave by hand.
module tb_axi_rd_mst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, start;
  logic [31:0] cfg_addr;
  logic [7:0]  cfg_len, cfg_num;
  logic        arvalid, arready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        busy, done, resp_err, last_err;
  logic [15:0] beat_total;
  logic [31:0] last_rdata;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  axi_rd_mst #(.ID_W(4), .ADDR_W(32), .LEN_W(8), .SIZE_W(3), .BURST_W(2),
               .DATA_W(32), .RESP_W(2), .NUM_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_num(cfg_num),
    .axi_mst_arvalid(arvalid), .axi_mst_arready(arready),
    .axi_mst_arid(arid), .axi_mst_araddr(araddr), .axi_mst_arlen(arlen),
    .axi_mst_arsize(arsize), .axi_mst_arburst(arburst),
    .axi_mst_rvalid(rvalid), .axi_mst_rready(rready),
    .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast),
    .busy(busy), .done(done), .resp_err(resp_err), .last_err(last_err),
    .beat_total(beat_total), .last_rdata(last_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle; on return we are at the negedge of cycle T+1
  task automatic do_start(input logic [31:0] a, input logic [7:0] l, input logic [7:0] n);
    cfg_addr = a; cfg_len = l; cfg_num = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expect an AR request right now, check its fields, then accept it
  task automatic ar_phase(input string tag, input logic [31:0] ea, input logic [3:0] eid,
                          input logic [7:0] el);
    check({tag, "_arvalid"}, 64'(arvalid), 64'd1);
    check({tag, "_araddr"}, 64'(araddr), 64'(ea));
    check({tag, "_arid"}, 64'(arid), 64'(eid));
    check({tag, "_arlen"}, 64'(arlen), 64'(el));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  // Present nb beats back to back; rlast asserted only on beat index lastpos
  task automatic r_beats(input string tag, input int nb, input logic [1:0] resp,
                         input int lastpos, input logic [31:0] dbase);
    for (int k = 0; k < nb; k++) begin
      rvalid = 1'b1; rdata = dbase + 32'(k); rresp = resp; rlast = (k == lastpos);
      check({tag, "_rready"}, 64'(rready), 64'd1);
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
  endtask

  // Called at the negedge after the final beat: done now, idle next cycle
  task automatic end_check(input string tag, input logic [15:0] et, input logic er,
                           input logic el, input logic [31:0] ed);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_fin"}, 64'(busy), 64'd1);
    check({tag, "_total"}, 64'(beat_total), 64'(et));
    check({tag, "_resp_err"}, 64'(resp_err), 64'(er));
    check({tag, "_last_err"}, 64'(last_err), 64'(el));
    check({tag, "_last_rdata"}, 64'(last_rdata), 64'(ed));
    @(negedge clk);
    check({tag, "_done_off"}, 64'(done), 64'd0);
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; start = 1'b0;
    cfg_addr = '0; cfg_len = '0; cfg_num = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_rready", 64'(rready), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arid", 64'(arid), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_errs", 64'({resp_err, last_err}), 64'd0);
    check("rst_total", 64'(beat_total), 64'd0);
    check("rst_rdata", 64'(last_rdata), 64'd0);
    check("arsize", 64'(arsize), 64'd2);
    check("arburst", 64'(arburst), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single 4-beat burst at address 0
    do_start(32'h0, 8'd3, 8'd1);
    check("t1_rready_addr", 64'(rready), 64'd0);
    ar_phase("t1", 32'h0, 4'd0, 8'd3);
    r_beats("t1", 4, 2'b00, 3, 32'hA0);
    end_check("t1", 16'd4, 1'b0, 1'b0, 32'hA3);

    // Three 2-beat bursts: address steps by 8, id steps by 1
    do_start(32'h100, 8'd1, 8'd3);
    ar_phase("t2a", 32'h100, 4'd0, 8'd1);
    r_beats("t2a", 2, 2'b00, 1, 32'h10);
    check("t2a_nodone", 64'(done), 64'd0);
    ar_phase("t2b", 32'h108, 4'd1, 8'd1);
    r_beats("t2b", 2, 2'b00, 1, 32'h20);
    ar_phase("t2c", 32'h110, 4'd2, 8'd1);
    r_beats("t2c", 2, 2'b00, 1, 32'h30);
    end_check("t2", 16'd6, 1'b0, 1'b0, 32'h31);

    // DECERR on a single beat: resp_err sticks after done
    do_start(32'h40, 8'd0, 8'd1);
    ar_phase("t3", 32'h40, 4'd0, 8'd0);
    r_beats("t3", 1, 2'b11, 0, 32'h77);
    end_check("t3", 16'd1, 1'b1, 1'b0, 32'h77);
    repeat (3) @(negedge clk);
    check("t3_hold", 64'(resp_err), 64'd1);

    // Early rlast on beat 2 of 4: last_err set, all 4 beats still consumed
    do_start(32'h500, 8'd3, 8'd1);
    check("t4_cleared", 64'(resp_err), 64'd0);
    ar_phase("t4", 32'h500, 4'd0, 8'd3);
    r_beats("t4", 4, 2'b00, 2, 32'h500);
    end_check("t4", 16'd4, 1'b0, 1'b1, 32'h503);

    // Zero bursts: done right away, no AR
    do_start(32'h900, 8'd2, 8'd0);
    check("t5_arvalid", 64'(arvalid), 64'd0);
    check("t5_total", 64'(beat_total), 64'd0);
    end_check("t5", 16'd0, 1'b0, 1'b0, 32'h503);

    // enable gating, arvalid held after enable drops, stray rvalid in ADDR ignored
    enable = 1'b0;
    do_start(32'h200, 8'd0, 8'd1);
    check("t6_gated", 64'(arvalid), 64'd0);
    check("t6_busy", 64'(busy), 64'd1);
    rvalid = 1'b1; rdata = 32'hDEAD; rresp = 2'b10;
    @(negedge clk);
    rvalid = 1'b0; rresp = 2'b00;
    check("t6_gated2", 64'(arvalid), 64'd0);
    check("t6_stray_total", 64'(beat_total), 64'd0);
    check("t6_stray_data", 64'(last_rdata), 64'h503);
    enable = 1'b1;
    @(negedge clk);
    check("t6_raised", 64'(arvalid), 64'd1);
    enable = 1'b0;
    #1 check("t6_held", 64'(arvalid), 64'd1);
    @(negedge clk);
    check("t6_held2", 64'(arvalid), 64'd1);
    ar_phase("t6", 32'h200, 4'd0, 8'd0);
    enable = 1'b1;
    r_beats("t6", 1, 2'b00, 0, 32'h6);
    end_check("t6", 16'd1, 1'b0, 1'b0, 32'h6);

    // Reset in the middle of a burst
    do_start(32'h700, 8'd3, 8'd2);
    ar_phase("t7", 32'h700, 4'd0, 8'd3);
    r_beats("t7", 2, 2'b00, -1, 32'h70);
    rvalid = 1'b1; rdata = 32'h72;
    rst_n = 1'b0;
    #1;
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_rready", 64'(rready), 64'd0);
    check("t7_total", 64'(beat_total), 64'd0);
    check("t7_rdata", 64'(last_rdata), 64'd0);
    check("t7_araddr", 64'(araddr), 64'd0);
    check("t7_arvalid", 64'(arvalid), 64'd0);
    check("t7_done", 64'(done), 64'd0);
    rvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t7_nodone", 64'(done), 64'd0);

    // Clean run after reset; start pulsed mid-sequence must be ignored
    do_start(32'h300, 8'd1, 8'd2);
    ar_phase("t8a", 32'h300, 4'd0, 8'd1);
    cfg_addr = 32'h999; cfg_len = 8'd5; cfg_num = 8'd1; start = 1'b1;
    rvalid = 1'b1; rdata = 32'h80; rresp = 2'b00; rlast = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rdata = 32'h81; rlast = 1'b1;
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0;
    ar_phase("t8b", 32'h308, 4'd1, 8'd1);
    r_beats("t8b", 2, 2'b00, 1, 32'h90);
    end_check("t8", 16'd4, 1'b0, 1'b0, 32'h91);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
